// File: rtl/mem_access_unit.sv
// Load/store initiator for the byte-addressable data memory: one request in flight, IDLE -> ACCESS -> WAIT -> RESP.
// Build with MAU_MISALIGN_TRAP_EN to turn misaligned half/word requests into error responses instead of aligning them.
module mem_access_unit #(
    parameter int NB_DATA_BUS = 32,
    parameter int NB_ADDRESS  = 3
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic                   i_req_we,
    input  logic [NB_ADDRESS-1:0]  i_req_addr,
    input  logic [1:0]             i_req_size,
    input  logic                   i_req_unsigned,
    input  logic [NB_DATA_BUS-1:0] i_req_wdata,
    output logic                   o_rsp_valid,
    output logic [NB_DATA_BUS-1:0] o_rsp_rdata,
    output logic                   o_rsp_err,
    output logic [NB_ADDRESS-1:0]  o_mem_r_addr,
    output logic                   o_mem_r_en,
    output logic [1:0]             o_mem_r_addressing,
    input  logic [NB_DATA_BUS-1:0] i_mem_r_data,
    output logic [NB_ADDRESS-1:0]  o_mem_w_addr,
    output logic [NB_DATA_BUS-1:0] o_mem_w_data,
    output logic                   o_mem_w_en,
    output logic [1:0]             o_mem_w_addressing
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    req_we;
    logic                    req_unsigned;
    logic [1:0]              req_size;
    logic                    accept;
    logic                    req_bad;
    logic [NB_ADDRESS-1:0]   aligned_addr;
    logic                    sign_bit;
    logic [NB_DATA_BUS-1:0]  load_ext;

    assign accept = (state == IDLE) && i_req_valid;

`ifdef MAU_MISALIGN_TRAP_EN
    assign req_bad = (i_req_size == 2'b10)
                   || ((i_req_size == 2'b01) && i_req_addr[0])
                   || ((i_req_size == 2'b00) && (i_req_addr[1:0] != 2'b00));
`else
    assign req_bad = (i_req_size == 2'b10);
`endif

    // In the trapping build an accepted address is already aligned, so this is a no-op there.
    always_comb begin
        aligned_addr = i_req_addr;
        if (i_req_size == 2'b01) begin
            aligned_addr[0] = 1'b0;
        end else if (i_req_size == 2'b00) begin
            aligned_addr[1:0] = 2'b00;
        end
    end

    always_comb begin
        sign_bit = 1'b0;
        load_ext = i_mem_r_data;
        case (req_size)
            2'b11: begin
                sign_bit = ~req_unsigned & i_mem_r_data[7];
                load_ext = {{(NB_DATA_BUS-8){sign_bit}}, i_mem_r_data[7:0]};
            end
            2'b01: begin
                sign_bit = ~req_unsigned & i_mem_r_data[15];
                load_ext = {{(NB_DATA_BUS-16){sign_bit}}, i_mem_r_data[15:0]};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_req_valid) state_nxt = req_bad ? RESP : ACCESS;
            ACCESS:  state_nxt = req_we ? RESP : WAIT;
            WAIT:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are loaded from the next state so each one lines up with the state it belongs to.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state              <= IDLE;
            req_we             <= 1'b0;
            req_unsigned       <= 1'b0;
            req_size           <= 2'b00;
            o_req_ready        <= 1'b1;
            o_rsp_valid        <= 1'b0;
            o_rsp_err          <= 1'b0;
            o_rsp_rdata        <= '0;
            o_mem_r_en         <= 1'b0;
            o_mem_r_addr       <= '0;
            o_mem_r_addressing <= 2'b00;
            o_mem_w_en         <= 1'b0;
            o_mem_w_addr       <= '0;
            o_mem_w_data       <= '0;
            o_mem_w_addressing <= 2'b00;
        end else begin
            state              <= state_nxt;
            o_req_ready        <= (state_nxt == IDLE);
            o_rsp_valid        <= (state_nxt == RESP);
            o_mem_r_en         <= 1'b0;
            o_mem_r_addr       <= '0;
            o_mem_r_addressing <= 2'b00;
            o_mem_w_en         <= 1'b0;
            o_mem_w_addr       <= '0;
            o_mem_w_data       <= '0;
            o_mem_w_addressing <= 2'b00;

            if (accept) begin
                req_we       <= i_req_we;
                req_unsigned <= i_req_unsigned;
                req_size     <= i_req_size;
                if (req_bad) begin
                    o_rsp_err   <= 1'b1;
                    o_rsp_rdata <= '0;
                end else if (i_req_we) begin
                    o_mem_w_en         <= 1'b1;
                    o_mem_w_addr       <= aligned_addr;
                    o_mem_w_data       <= i_req_wdata;
                    o_mem_w_addressing <= i_req_size;
                end else begin
                    o_mem_r_en         <= 1'b1;
                    o_mem_r_addr       <= aligned_addr;
                    o_mem_r_addressing <= i_req_size;
                end
            end

            if ((state == ACCESS) && req_we) begin
                o_rsp_err   <= 1'b0;
                o_rsp_rdata <= '0;
            end

            if (state == WAIT) begin
                o_rsp_err   <= 1'b0;
                o_rsp_rdata <= load_ext;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array memory device plus a spec-level request model; random and directed requests.
module tb_mem_access_unit;
    localparam int NBD = 32;
    localparam int NBA = 3;
`ifdef MAU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic           i_req_valid;
    logic           o_req_ready;
    logic           i_req_we;
    logic [NBA-1:0] i_req_addr;
    logic [1:0]     i_req_size;
    logic           i_req_unsigned;
    logic [NBD-1:0] i_req_wdata;
    logic           o_rsp_valid;
    logic [NBD-1:0] o_rsp_rdata;
    logic           o_rsp_err;
    logic [NBA-1:0] o_mem_r_addr;
    logic           o_mem_r_en;
    logic [1:0]     o_mem_r_addressing;
    logic [NBD-1:0] i_mem_r_data;
    logic [NBA-1:0] o_mem_w_addr;
    logic [NBD-1:0] o_mem_w_data;
    logic           o_mem_w_en;
    logic [1:0]     o_mem_w_addressing;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] model_mem [8];
    logic [7:0] phys [8];

    mem_access_unit #(.NB_DATA_BUS(NBD), .NB_ADDRESS(NBA)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_size(i_req_size),
        .i_req_unsigned(i_req_unsigned), .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
        .o_mem_r_addr(o_mem_r_addr), .o_mem_r_en(o_mem_r_en),
        .o_mem_r_addressing(o_mem_r_addressing), .i_mem_r_data(i_mem_r_data),
        .o_mem_w_addr(o_mem_w_addr), .o_mem_w_data(o_mem_w_data),
        .o_mem_w_en(o_mem_w_en), .o_mem_w_addressing(o_mem_w_addressing)
    );

    always #5 i_clk = ~i_clk;

    function automatic int nbytes(input logic [1:0] s);
        case (s)
            2'b11:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    // Memory device: registered read, write commits at the edge that samples w_en.
    always @(posedge i_clk) begin : mem_dev
        logic [31:0] rbuf;
        rbuf = '0;
        if (o_mem_w_en)
            for (int b = 0; b < nbytes(o_mem_w_addressing); b++)
                phys[(int'(o_mem_w_addr) + b) % 8] <= o_mem_w_data[8*b +: 8];
        if (o_mem_r_en) begin
            for (int b = 0; b < nbytes(o_mem_r_addressing); b++)
                rbuf[8*b +: 8] = phys[(int'(o_mem_r_addr) + b) % 8];
            i_mem_r_data <= rbuf;
        end
    end

    // Issue one request, check the memory-port activity and response against the model.
    // Latency counts cycles from the accept cycle to the cycle with o_rsp_valid high.
    task automatic do_req(input logic we, input logic [2:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata, input bit hold,
                          output logic [31:0] rd);
        int          nb;
        int          a;
        int          ea_i;
        bit          misalign;
        bit          bad;
        int          exp_lat;
        int          lat;
        int          en_cnt;
        logic [2:0]  ea;
        logic [31:0] exp_rd;
        logic [2:0]  seen_addr;

        nb       = nbytes(size);
        a        = int'(addr);
        ea_i     = a - (a % nb);
        ea       = 3'(ea_i);
        misalign = (a % nb) != 0;
        bad      = (size == 2'b10) || (TRAP && misalign);
        exp_lat  = bad ? 1 : (we ? 2 : 3);
        exp_rd   = '0;
        if (!bad && !we) begin
            for (int b = 0; b < nb; b++) exp_rd = exp_rd | (32'(model_mem[ea_i + b]) << (8*b));
            if (nb < 4 && !uns && exp_rd[8*nb-1]) exp_rd = exp_rd | (32'hffffffff << (8*nb));
        end
        if (!bad && we)
            for (int b = 0; b < nb; b++) model_mem[ea_i + b] = wdata[8*b +: 8];

        @(negedge i_clk);
        n_cmp++;
        if (o_req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_idle: got %b want 1", o_req_ready);
        end
        i_req_valid    = 1'b1;
        i_req_we       = we;
        i_req_addr     = addr;
        i_req_size     = size;
        i_req_unsigned = uns;
        i_req_wdata    = wdata;
        @(posedge i_clk);
        #1;
        if (!hold) i_req_valid = 1'b0;

        lat    = -1;
        en_cnt = 0;
        for (int k = 0; k <= 6 && lat < 0; k++) begin
            if (k > 0) begin
                @(posedge i_clk);
                #1;
            end
            if (o_mem_w_en || o_mem_r_en) begin
                en_cnt++;
                seen_addr = we ? o_mem_w_addr : o_mem_r_addr;
                n_cmp++;
                if (o_mem_w_en !== we || o_mem_r_en !== !we || seen_addr !== ea ||
                    (we ? o_mem_w_addressing : o_mem_r_addressing) !== size ||
                    (we && o_mem_w_data !== wdata)) begin
                    n_bad++;
                    $display("FAIL mem_port: got w_en=%b r_en=%b addr=%0d size=%b wdata=%h want we=%b addr=%0d size=%b wdata=%h",
                             o_mem_w_en, o_mem_r_en, seen_addr,
                             we ? o_mem_w_addressing : o_mem_r_addressing, o_mem_w_data, we, ea, size, wdata);
                end
            end
            if (o_rsp_valid) lat = k + 1;
        end
        if (hold) i_req_valid = 1'b0;

        n_cmp++;
        if (lat != exp_lat) begin
            n_bad++;
            $display("FAIL latency: got %0d want %0d (we=%b addr=%0d size=%b)", lat, exp_lat, we, addr, size);
        end
        n_cmp++;
        if (en_cnt != (bad ? 0 : 1)) begin
            n_bad++;
            $display("FAIL enable_count: got %0d want %0d", en_cnt, bad ? 0 : 1);
        end
        n_cmp++;
        if (o_rsp_err !== bad || o_rsp_rdata !== exp_rd) begin
            n_bad++;
            $display("FAIL response: got err=%b rdata=%h want err=%b rdata=%h (we=%b addr=%0d size=%b uns=%b)",
                     o_rsp_err, o_rsp_rdata, bad, exp_rd, we, addr, size, uns);
        end
        rd = o_rsp_rdata;
        @(posedge i_clk);
        #1;
        n_cmp++;
        if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1 || o_rsp_rdata !== exp_rd) begin
            n_bad++;
            $display("FAIL after_resp: got valid=%b ready=%b rdata=%h want 0 1 %h",
                     o_rsp_valid, o_req_ready, o_rsp_rdata, exp_rd);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_cmp++;
        if (o_req_ready !== 1'b1 ||
            {o_rsp_valid, o_rsp_err, o_rsp_rdata, o_mem_r_en, o_mem_w_en, o_mem_r_addr, o_mem_w_addr,
             o_mem_r_addressing, o_mem_w_addressing, o_mem_w_data} !== '0) begin
            n_bad++;
            $display("FAIL %s: got ready=%b valid=%b err=%b rdata=%h r_en=%b w_en=%b w_data=%h want ready=1, rest 0",
                     tag, o_req_ready, o_rsp_valid, o_rsp_err, o_rsp_rdata, o_mem_r_en, o_mem_w_en, o_mem_w_data);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        #12;
        check_reset_outputs("reset_values");
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    task automatic test_store_load();
        logic [31:0] rd;
        do_req(1'b1, 3'd0, 2'b00, 1'b0, 32'h0123abcd, 1'b0, rd);
        do_req(1'b1, 3'd4, 2'b00, 1'b0, 32'h89abcdef, 1'b0, rd);
        do_req(1'b0, 3'd0, 2'b00, 1'b0, 32'h0, 1'b0, rd);
        n_cmp++;
        if (rd !== 32'h0123abcd) begin n_bad++; $display("FAIL load_word: got %h want 0123abcd", rd); end
        do_req(1'b0, 3'd0, 2'b11, 1'b0, 32'h0, 1'b0, rd);
        n_cmp++;
        if (rd !== 32'hffffffcd) begin n_bad++; $display("FAIL load_byte_s: got %h want ffffffcd", rd); end
        do_req(1'b0, 3'd0, 2'b11, 1'b1, 32'h0, 1'b0, rd);
        n_cmp++;
        if (rd !== 32'h000000cd) begin n_bad++; $display("FAIL load_byte_u: got %h want 000000cd", rd); end
        do_req(1'b0, 3'd2, 2'b01, 1'b0, 32'h0, 1'b0, rd);
        n_cmp++;
        if (rd !== 32'h00000123) begin n_bad++; $display("FAIL load_half_s: got %h want 00000123", rd); end
    endtask

    task automatic test_misalign();
        logic [31:0] rd;
        logic [31:0] want;
        want = TRAP ? 32'h0 : 32'hffffabcd;
        do_req(1'b0, 3'd1, 2'b01, 1'b0, 32'h0, 1'b0, rd);
        n_cmp++;
        if (rd !== want) begin n_bad++; $display("FAIL load_half_misaligned: got %h want %h", rd, want); end
        do_req(1'b0, 3'd6, 2'b00, 1'b0, 32'h0, 1'b0, rd);
    endtask

    task automatic test_reserved_and_hold();
        logic [31:0] rd;
        do_req(1'b0, 3'd0, 2'b10, 1'b0, 32'h0, 1'b1, rd);
        do_req(1'b1, 3'd4, 2'b10, 1'b0, 32'h55aa55aa, 1'b0, rd);
        do_req(1'b0, 3'd4, 2'b00, 1'b0, 32'h0, 1'b1, rd);
        do_req(1'b1, 3'd6, 2'b01, 1'b0, 32'h0000beef, 1'b1, rd);
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] rd;
        // Load aborted in WAIT.
        @(negedge i_clk);
        i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 3'd0; i_req_size = 2'b00; i_req_unsigned = 1'b0;
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        #1;
        check_reset_outputs("reset_in_wait");
        for (int k = 0; k < 2; k++) begin
            @(posedge i_clk);
            #1;
            n_cmp++;
            if (o_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL no_rsp_in_reset: got %b want 0", o_rsp_valid); end
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        // Store aborted while its write enable is high: memory must keep the old word.
        @(negedge i_clk);
        i_req_valid = 1'b1; i_req_we = 1'b1; i_req_addr = 3'd4; i_req_size = 2'b00; i_req_wdata = 32'hdeadbeef;
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b0;
        i_rst = 1'b1;
        #1;
        check_reset_outputs("reset_in_access");
        @(negedge i_clk);
        i_rst = 1'b0;
        do_req(1'b0, 3'd4, 2'b00, 1'b0, 32'h0, 1'b0, rd);
        do_req(1'b0, 3'd0, 2'b00, 1'b0, 32'h0, 1'b0, rd);
        n_cmp++;
        if (rd !== 32'h0123abcd) begin n_bad++; $display("FAIL load_after_reset: got %h want 0123abcd", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd;
        for (int i = 0; i < 60; i++)
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), rd);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) model_mem[i] = 8'h00;
        i_rst          = 1'b0;
        i_req_valid    = 1'b0;
        i_req_we       = 1'b0;
        i_req_addr     = '0;
        i_req_size     = 2'b00;
        i_req_unsigned = 1'b0;
        i_req_wdata    = '0;
        test_reset();
        test_store_load();
        test_misalign();
        test_reserved_and_hold();
        test_reset_mid_op();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
